// File: rtl/alu_writeback.sv
// Write-back stage behind the MIPS ALU: a two-entry result buffer that drives the
// register-file write port and answers forwarding lookups on pending results.
module alu_writeback #(
  parameter int         DATA_W      = 32,
  parameter int         REG_AW      = 5,
  parameter bit         R0_WRITABLE = 1'b1,
  parameter logic [3:0] ILLEGAL_CTL = 4'hF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              Zero,
  input  logic [3:0]        ALUCtl,
  input  logic [REG_AW-1:0] WriteRegIn,
  input  logic              wb_ready,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              ZeroOut,
  input  logic [REG_AW-1:0] fwd_reg1,
  input  logic [REG_AW-1:0] fwd_reg2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [15:0]       retired_cnt,
  output logic [7:0]        illegal_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              head_q, head_d;
  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic              zero_q [2];
  logic              zero_d [2];
  logic [REG_AW-1:0] reg_q  [2];
  logic [REG_AW-1:0] reg_d  [2];
  logic [3:0]        ctl_q  [2];
  logic [3:0]        ctl_d  [2];
  logic [15:0]       retired_q, retired_d;
  logic [7:0]        illegal_q, illegal_d;

  logic [1:0]        ent_vld;
  logic [1:0]        ent_disc;
  logic              head_vld;
  logic              head_disc;
  logic              tail_idx;
  logic              wr_idx;
  logic              push;
  logic              pop;

  logic [REG_AW-1:0] fwd_idx    [2];
  logic              fwd_hit_w  [2];
  logic [DATA_W-1:0] fwd_data_w [2];

  // Entry validity follows from occupancy: the head slot is live unless EMPTY,
  // the other slot only when both are in use.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ent
    localparam logic IDX = 1'(gi);
    assign ent_vld[gi]  = (IDX == head_q) ? (state_q != ST_EMPTY) : (state_q == ST_TWO);
    assign ent_disc[gi] = (ctl_q[gi] == ILLEGAL_CTL) ||
                          (!R0_WRITABLE && (reg_q[gi] == '0));
  end

  assign head_vld  = (state_q != ST_EMPTY);
  assign head_disc = ent_disc[head_q];
  assign tail_idx  = ~head_q;
  assign in_ready  = (state_q != ST_TWO);
  assign push      = in_valid & in_ready;
  assign pop       = head_vld & (wb_ready | head_disc);
  // In ONE the new result lands behind the head even if the head pops this cycle.
  assign wr_idx    = head_q ^ (state_q == ST_ONE);

  assign RegWrite  = head_vld & wb_ready & ~head_disc;
  assign WriteReg  = head_vld ? reg_q[head_q]  : '0;
  assign WriteData = head_vld ? data_q[head_q] : '0;
  assign ZeroOut   = head_vld ? zero_q[head_q] : 1'b0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_TWO;
        else if (!push && pop) state_d = ST_EMPTY;
      end
      ST_TWO:   if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    head_d = head_q ^ pop;
  end

  always_comb begin
    data_d = data_q;
    zero_d = zero_q;
    reg_d  = reg_q;
    ctl_d  = ctl_q;
    if (push) begin
      data_d[wr_idx] = ALUOut;
      zero_d[wr_idx] = Zero;
      reg_d[wr_idx]  = WriteRegIn;
      ctl_d[wr_idx]  = ALUCtl;
    end
  end

  always_comb begin
    retired_d = retired_q + 16'(RegWrite);
    illegal_d = illegal_q;
    if (pop && (ctl_q[head_q] == ILLEGAL_CTL) && (illegal_q != 8'hFF))
      illegal_d = illegal_q + 8'd1;
  end

  // Older entry is checked first so a younger match overrides it.
  always_comb begin
    fwd_idx[0] = fwd_reg1;
    fwd_idx[1] = fwd_reg2;
    for (int p = 0; p < 2; p++) begin
      fwd_hit_w[p]  = 1'b0;
      fwd_data_w[p] = '0;
      if (ent_vld[head_q] && !ent_disc[head_q] && (reg_q[head_q] == fwd_idx[p])) begin
        fwd_hit_w[p]  = 1'b1;
        fwd_data_w[p] = data_q[head_q];
      end
      if (ent_vld[tail_idx] && !ent_disc[tail_idx] && (reg_q[tail_idx] == fwd_idx[p])) begin
        fwd_hit_w[p]  = 1'b1;
        fwd_data_w[p] = data_q[tail_idx];
      end
    end
  end

  assign fwd_hit1    = fwd_hit_w[0];
  assign fwd_hit2    = fwd_hit_w[1];
  assign fwd_data1   = fwd_data_w[0];
  assign fwd_data2   = fwd_data_w[1];
  assign retired_cnt = retired_q;
  assign illegal_cnt = illegal_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_EMPTY;
      head_q    <= 1'b0;
      retired_q <= '0;
      illegal_q <= '0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        zero_q[i] <= 1'b0;
        reg_q[i]  <= '0;
        ctl_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= data_d[i];
        zero_q[i] <= zero_d[i];
        reg_q[i]  <= reg_d[i];
        ctl_q[i]  <= ctl_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: two instances (reg 0 writable / not) driven in lockstep
// and compared every cycle against a queue-style model of the write-back buffer.
module tb_alu_writeback;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic [31:0] ALUOut;
  logic        Zero;
  logic [3:0]  ALUCtl;
  logic [4:0]  WriteRegIn;
  logic        wb_ready;
  logic [4:0]  fwd_reg1, fwd_reg2;

  logic        ir_a, rw_a, z_a, h1_a, h2_a;
  logic [4:0]  wr_a;
  logic [31:0] wd_a, d1_a, d2_a;
  logic [15:0] rc_a;
  logic [7:0]  ic_a;
  logic        ir_b, rw_b, z_b, h1_b, h2_b;
  logic [4:0]  wr_b;
  logic [31:0] wd_b, d1_b, d2_b;
  logic [15:0] rc_b;
  logic [7:0]  ic_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  alu_writeback #(.DATA_W(32), .REG_AW(5), .R0_WRITABLE(1'b1), .ILLEGAL_CTL(4'hF)) dut_a (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir_a), .ALUOut(ALUOut),
    .Zero(Zero), .ALUCtl(ALUCtl), .WriteRegIn(WriteRegIn), .wb_ready(wb_ready),
    .RegWrite(rw_a), .WriteReg(wr_a), .WriteData(wd_a), .ZeroOut(z_a),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(h1_a), .fwd_hit2(h2_a),
    .fwd_data1(d1_a), .fwd_data2(d2_a), .retired_cnt(rc_a), .illegal_cnt(ic_a));

  alu_writeback #(.DATA_W(32), .REG_AW(5), .R0_WRITABLE(1'b0), .ILLEGAL_CTL(4'hF)) dut_b (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(ir_b), .ALUOut(ALUOut),
    .Zero(Zero), .ALUCtl(ALUCtl), .WriteRegIn(WriteRegIn), .wb_ready(wb_ready),
    .RegWrite(rw_b), .WriteReg(wr_b), .WriteData(wd_b), .ZeroOut(z_b),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(h1_b), .fwd_hit2(h2_b),
    .fwd_data1(d1_b), .fwd_data2(d2_b), .retired_cnt(rc_b), .illegal_cnt(ic_b));

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic [4:0]  r;
    logic [3:0]  c;
  } ent_t;

  // Model: per instance an ordered list of pending results (index 0 = oldest).
  ent_t m_ent [2][2];
  int   m_cnt [2];
  int   m_ret [2];
  int   m_ill [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instance 1 is the one where reg 0 is not writable.
  function automatic bit m_disc(input int k, input ent_t e);
    return (e.c == 4'hF) || (k == 1 && e.r == 5'd0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_ret[k] = 0;
      m_ill[k] = 0;
    end
  endtask

  task automatic check_one(input int k, input logic ir, input logic rw, input logic [4:0] wr,
                           input logic [31:0] wd, input logic z, input logic h1, input logic h2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [15:0] rc,
                           input logic [7:0] ic);
    ent_t        hd;
    logic        e_h1, e_h2;
    logic [31:0] e_d1, e_d2;
    string       p;
    p    = (k == 0) ? "r0w1" : "r0w0";
    hd   = (m_cnt[k] > 0) ? m_ent[k][0] : '0;
    e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
    for (int i = 0; i < m_cnt[k]; i++) begin
      if (!m_disc(k, m_ent[k][i]) && m_ent[k][i].r == fwd_reg1) begin e_h1 = 1'b1; e_d1 = m_ent[k][i].d; end
      if (!m_disc(k, m_ent[k][i]) && m_ent[k][i].r == fwd_reg2) begin e_h2 = 1'b1; e_d2 = m_ent[k][i].d; end
    end
    chk({p, ".in_ready"}, 32'(ir), 32'(m_cnt[k] < 2));
    chk({p, ".RegWrite"}, 32'(rw), 32'(m_cnt[k] > 0 && wb_ready && !m_disc(k, hd)));
    chk({p, ".WriteReg"}, 32'(wr), 32'(hd.r));
    chk({p, ".WriteData"}, wd, hd.d);
    chk({p, ".ZeroOut"}, 32'(z), 32'(hd.z));
    chk({p, ".fwd_hit1"}, 32'(h1), 32'(e_h1));
    chk({p, ".fwd_hit2"}, 32'(h2), 32'(e_h2));
    chk({p, ".fwd_data1"}, d1, e_d1);
    chk({p, ".fwd_data2"}, d2, e_d2);
    chk({p, ".retired_cnt"}, 32'(rc), m_ret[k] & 32'hFFFF);
    chk({p, ".illegal_cnt"}, 32'(ic), 32'(m_ill[k]));
  endtask

  task automatic model_update(input int k);
    bit   do_push, do_pop, do_wr;
    ent_t nw;
    do_push = in_valid && (m_cnt[k] < 2);
    do_pop  = (m_cnt[k] > 0) && (wb_ready || m_disc(k, m_ent[k][0]));
    do_wr   = (m_cnt[k] > 0) && wb_ready && !m_disc(k, m_ent[k][0]);
    if (do_wr) m_ret[k] = (m_ret[k] + 1) % 65536;
    if (do_pop && m_ent[k][0].c == 4'hF && m_ill[k] < 255) m_ill[k]++;
    if (do_pop) begin
      m_ent[k][0] = m_ent[k][1];
      m_cnt[k]--;
    end
    if (do_push) begin
      nw = '{d: ALUOut, z: Zero, r: WriteRegIn, c: ALUCtl};
      m_ent[k][m_cnt[k]] = nw;
      m_cnt[k]++;
    end
  endtask

  task automatic check_all();
    check_one(0, ir_a, rw_a, wr_a, wd_a, z_a, h1_a, h2_a, d1_a, d2_a, rc_a, ic_a);
    check_one(1, ir_b, rw_b, wr_b, wd_b, z_b, h1_b, h2_b, d1_b, d2_b, rc_b, ic_b);
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one cycle.
  task automatic step();
    #1;
    check_all();
    model_update(0);
    model_update(1);
    @(negedge CLK);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic z, input logic [3:0] c,
                       input logic [4:0] r, input logic wbr);
    in_valid = v; ALUOut = d; Zero = z; ALUCtl = c; WriteRegIn = r; wb_ready = wbr;
  endtask

  initial begin
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    fwd_reg1 = 5'd0;
    fwd_reg2 = 5'd0;
    model_reset();
    @(negedge CLK);
    #1;
    check_all();
    @(negedge CLK);
    RESET = 1'b1;
    step();

    // ADD 3+4 -> r2, written the following cycle
    drive(1, 32'd7, 0, 4'h2, 5'd2, 1);
    step();
    drive(0, 0, 0, 4'h2, 5'd0, 1);
    #1;
    chk("t1.RegWrite", 32'(rw_a), 32'd1);
    chk("t1.WriteData", wd_a, 32'd7);
    step();
    #1;
    chk("t1.retired_cnt", 32'(rc_a), 32'd1);

    // Back-pressure: fill to TWO, hold a third push, then drain
    drive(1, 32'd5, 0, 4'h2, 5'd8, 0);   step();
    drive(1, 32'd13, 0, 4'h2, 5'd11, 0); step();
    drive(1, 32'd99, 1, 4'h6, 5'd3, 0);
    #1;
    chk("t2.in_ready", 32'(ir_a), 32'd0);
    step();
    drive(1, 32'd99, 1, 4'h6, 5'd3, 1);  step();
    drive(0, 0, 0, 4'h2, 5'd0, 1);
    repeat (3) step();

    // Forwarding: younger of two r14 entries wins, unmatched index misses
    drive(1, 32'd1, 0, 4'h2, 5'd14, 0);  step();
    drive(1, 32'd0, 1, 4'h6, 5'd14, 0);  step();
    drive(0, 0, 0, 4'h2, 5'd0, 0);
    fwd_reg1 = 5'd14;
    fwd_reg2 = 5'd20;
    #1;
    chk("t3.fwd_hit1", 32'(h1_a), 32'd1);
    chk("t3.fwd_data1", d1_a, 32'd0);
    chk("t3.fwd_hit2", 32'(h2_a), 32'd0);
    step();
    drive(0, 0, 0, 4'h2, 5'd0, 1);
    repeat (2) step();

    // Illegal results are dropped without waiting on wb_ready; counter saturates
    drive(1, 32'hDEAD, 0, 4'hF, 5'd9, 0); step();
    drive(0, 0, 0, 4'h2, 5'd0, 0);        step();
    #1;
    chk("t4.illegal_cnt", 32'(ic_a), 32'd1);
    drive(1, 32'hBEEF, 0, 4'hF, 5'd9, 0);
    repeat (300) step();
    drive(0, 0, 0, 4'h2, 5'd0, 0);
    repeat (2) step();
    #1;
    chk("t4.illegal_sat", 32'(ic_a), 32'hFF);

    // Writes to reg 0: dropped in one instance, normal in the other
    drive(1, 32'h55, 0, 4'h2, 5'd0, 1); step();
    drive(0, 0, 0, 4'h2, 5'd0, 1);
    #1;
    chk("t5.RegWrite_r0w0", 32'(rw_b), 32'd0);
    chk("t5.RegWrite_r0w1", 32'(rw_a), 32'd1);
    repeat (2) step();

    // Random traffic with small register indices to exercise forwarding overlap
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      fwd_reg1 = 5'($urandom_range(0, 3));
      fwd_reg2 = 5'($urandom_range(0, 3));
      step();
    end

    // Reset while full: outputs clear immediately, nothing written afterwards
    drive(1, 32'd21, 0, 4'h2, 5'd4, 0); step();
    drive(1, 32'd22, 0, 4'h2, 5'd5, 0); step();
    drive(1, 32'd23, 0, 4'h2, 5'd6, 0); step();
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge CLK);
    drive(0, 0, 0, 4'h2, 5'd0, 1);
    RESET = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
